// File: rtl/qsn_ctrl_param_pipe.sv
// Two-stage pipelined controller for the QSN cyclic barrel shifter: turns a per-column shift
// factor (absolute or relative to a per-column history) into registered left/right/merge selects.
module qsn_ctrl_param_pipe #(
   parameter int PERMUTATION_LENGTH = 5,
   parameter int SHIFT_W            = $clog2(PERMUTATION_LENGTH),
   parameter int COL_NUM            = 4,
   parameter int COL_W              = (COL_NUM > 1) ? $clog2(COL_NUM) : 1
) (
   input  logic                          sys_clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [SHIFT_W-1:0]            shift_in,
   input  logic [COL_W-1:0]              col_addr,
   input  logic                          delta_mode,
   input  logic                          hist_clr,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [SHIFT_W-1:0]            left_sel,
   output logic [SHIFT_W-1:0]            right_sel,
   output logic [PERMUTATION_LENGTH-2:0] merge_sel,
   output logic                          out_err
);

   localparam int               HIST_DEPTH = 2 ** COL_W;
   localparam logic [SHIFT_W:0] Z_EXT      = (SHIFT_W + 1)'(PERMUTATION_LENGTH);
   localparam logic [COL_W:0]   COL_EXT    = (COL_W + 1)'(COL_NUM);

   logic                          v1_q, v2_q;
   logic [SHIFT_W-1:0]            s1_q;
   logic                          err1_q;
   logic [SHIFT_W-1:0]            hist_q [HIST_DEPTH];

   logic [SHIFT_W-1:0]            left_q, right_q;
   logic [PERMUTATION_LENGTH-2:0] merge_q;
   logic                          err2_q;

   logic                          shiftErr, colErr, accept, adv2;
   logic [SHIFT_W-1:0]            shiftSan, histRd, s1_d;
   logic [SHIFT_W:0]              deltaSum, deltaMod;
   logic                          err1_d;

   logic [SHIFT_W:0]              rightExt;
   logic [SHIFT_W-1:0]            left_d, right_d;
   logic [PERMUTATION_LENGTH-2:0] merge_d;

   // Range checks only exist when the port width can encode illegal values.
   if (PERMUTATION_LENGTH < 2 ** SHIFT_W) begin : g_shiftChk
      assign shiftErr = ({1'b0, shift_in} >= Z_EXT);
   end else begin : g_noShiftChk
      assign shiftErr = 1'b0;
   end

   if (COL_NUM < HIST_DEPTH) begin : g_colChk
      assign colErr = delta_mode && ({1'b0, col_addr} >= COL_EXT);
   end else begin : g_noColChk
      assign colErr = 1'b0;
   end

   // Stage 2 can refill when empty or draining; stage 1 can refill when stage 2 can.
   assign adv2     = !v2_q || out_ready;
   assign in_ready = !v1_q || adv2;
   assign accept   = in_valid && in_ready;

   // Effective shift: a same-cycle clear makes the history read as zero.
   always_comb begin
      shiftSan = shiftErr ? '0 : shift_in;
      histRd   = hist_clr ? '0 : hist_q[col_addr];
      deltaSum = {1'b0, shiftSan} + Z_EXT - {1'b0, histRd};
      deltaMod = (deltaSum >= Z_EXT) ? (deltaSum - Z_EXT) : deltaSum;
      s1_d     = (delta_mode && !colErr) ? deltaMod[SHIFT_W-1:0] : shiftSan;
      err1_d   = shiftErr || colErr;
   end

   // Stage 1 register: effective shift and error flag of the accepted transaction.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         v1_q   <= 1'b0;
         s1_q   <= '0;
         err1_q <= 1'b0;
      end else if (in_ready) begin
         v1_q <= in_valid;
         if (accept) begin
            s1_q   <= s1_d;
            err1_q <= err1_d;
         end
      end
   end

   // History table: the accept's write is placed after the clear so it survives it.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < HIST_DEPTH; i++) begin
            hist_q[i] <= '0;
         end
      end else begin
         if (hist_clr) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
               hist_q[i] <= '0;
            end
         end
         if (accept && delta_mode && !colErr) begin
            hist_q[col_addr] <= shiftSan;
         end
      end
   end

   // Select words: right is the complementary rotation, merge marks lanes below Z-s.
   always_comb begin
      left_d   = s1_q;
      rightExt = Z_EXT - {1'b0, s1_q};
      right_d  = '0;
      merge_d  = '0;
      if (s1_q != '0) begin
         right_d = rightExt[SHIFT_W-1:0];
         for (int i = 0; i < PERMUTATION_LENGTH - 1; i++) begin
            merge_d[i] = (i < int'(rightExt));
         end
      end
   end

   // Stage 2 register: outputs only move when the downstream slot is free.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         v2_q    <= 1'b0;
         left_q  <= '0;
         right_q <= '0;
         merge_q <= '0;
         err2_q  <= 1'b0;
      end else if (adv2) begin
         v2_q <= v1_q;
         if (v1_q) begin
            left_q  <= left_d;
            right_q <= right_d;
            merge_q <= merge_d;
            err2_q  <= err1_q;
         end
      end
   end

   assign out_valid = v2_q;
   assign left_sel  = left_q;
   assign right_sel = right_q;
   assign merge_sel = merge_q;
   assign out_err   = err2_q;

endmodule

// File: tb/tb_qsn_ctrl_param_pipe.sv
// Bench for qsn_ctrl_param_pipe: directed table, backpressure/reset sequences and random
// traffic against a queue-based reference model; Z=7 and Z=2 instances stream all shifts.
module tb_qsn_ctrl_param_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       inValid, inReady, deltaMode, histClr, outValid, outReady, outErr;
   logic [2:0] shiftIn, leftSel, rightSel;
   logic [1:0] colAddr;
   logic [3:0] mergeSel;

   logic       in7Valid, in7Ready, out7Valid, out7Err;
   logic [2:0] shift7, left7, right7;
   logic [5:0] merge7;

   logic       in2Valid, in2Ready, out2Valid, out2Err;
   logic [0:0] shift2, left2, right2, merge2;

   qsn_ctrl_param_pipe #(.PERMUTATION_LENGTH(5), .COL_NUM(4)) dut5 (
      .sys_clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .shift_in(shiftIn),
      .col_addr(colAddr), .delta_mode(deltaMode), .hist_clr(histClr), .out_valid(outValid),
      .out_ready(outReady), .left_sel(leftSel), .right_sel(rightSel), .merge_sel(mergeSel),
      .out_err(outErr));

   qsn_ctrl_param_pipe #(.PERMUTATION_LENGTH(7), .COL_NUM(4)) dut7 (
      .sys_clk(clk), .rst(rst), .in_valid(in7Valid), .in_ready(in7Ready), .shift_in(shift7),
      .col_addr(2'd0), .delta_mode(1'b0), .hist_clr(1'b0), .out_valid(out7Valid),
      .out_ready(1'b1), .left_sel(left7), .right_sel(right7), .merge_sel(merge7),
      .out_err(out7Err));

   qsn_ctrl_param_pipe #(.PERMUTATION_LENGTH(2), .COL_NUM(4)) dut2 (
      .sys_clk(clk), .rst(rst), .in_valid(in2Valid), .in_ready(in2Ready), .shift_in(shift2),
      .col_addr(2'd0), .delta_mode(1'b0), .hist_clr(1'b0), .out_valid(out2Valid),
      .out_ready(1'b1), .left_sel(left2), .right_sel(right2), .merge_sel(merge2),
      .out_err(out2Err));

   typedef struct {
      int left;
      int right;
      int merge;
      int err;
      int cyc;
   } expT;

   typedef struct {
      int shift;
      bit delta;
      int col;
      bit clr;
      int left;
      int right;
      int merge;
      int err;
   } vecT;

   expT  q5[$], q7[$], q2[$];
   int   modelHist[4];
   int   cycleCnt = 0;
   int   testsRun = 0;
   int   testsFailed = 0;
   bit   stallPrev = 0;
   bit   useTable = 0;
   bit   lastAccept = 0;
   expT  tableExp;
   int   heldL, heldR, heldM, heldE;
   vecT  vecs[21];

   // Expected selects straight from the rotation rules: merge is a run of Z-s low ones.
   function automatic expT selFor(int z, int s, int err);
      expT e;
      e.left  = s;
      e.right = (z - s) % z;
      e.merge = (s == 0) ? 0 : ((1 << (z - s)) - 1);
      e.err   = err;
      e.cyc   = 0;
      return e;
   endfunction

   function automatic expT modelAccept(int shift, bit delta, int col, bit clr);
      int sh, h, s, err;
      err = (shift >= 5) ? 1 : 0;
      sh  = (err != 0) ? 0 : shift;
      h   = clr ? 0 : modelHist[col];
      s   = delta ? ((sh - h + 5) % 5) : sh;
      if (clr) begin
         for (int i = 0; i < 4; i++) modelHist[i] = 0;
      end
      if (delta) modelHist[col] = sh;
      return selFor(5, s, err);
   endfunction

   task automatic checkOutput(string name, int got, int want);
      testsRun++;
      if (got != want) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic boundFail(string name);
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: bound expired, got timeout, want completion", name);
   endtask

   // One clock: inputs are set just after a rising edge, everything is sampled at the falling edge.
   task automatic cycleStep();
      expT e, m;
      @(negedge clk);
      if (stallPrev && outValid) begin
         checkOutput("held left_sel", int'(leftSel), heldL);
         checkOutput("held right_sel", int'(rightSel), heldR);
         checkOutput("held merge_sel", int'(mergeSel), heldM);
         checkOutput("held out_err", int'(outErr), heldE);
      end
      if (outValid && outReady) begin
         if (q5.size() == 0) begin
            checkOutput("spurious out_valid", int'(outValid), 0);
         end else begin
            e = q5.pop_front();
            checkOutput("left_sel", int'(leftSel), e.left);
            checkOutput("right_sel", int'(rightSel), e.right);
            checkOutput("merge_sel", int'(mergeSel), e.merge);
            checkOutput("out_err", int'(outErr), e.err);
         end
      end
      stallPrev  = outValid && !outReady;
      heldL      = int'(leftSel);
      heldR      = int'(rightSel);
      heldM      = int'(mergeSel);
      heldE      = int'(outErr);
      lastAccept = inValid && inReady;
      if (lastAccept) begin
         m = modelAccept(int'(shiftIn), deltaMode, int'(colAddr), histClr);
         q5.push_back(useTable ? tableExp : m);
      end else if (histClr) begin
         for (int i = 0; i < 4; i++) modelHist[i] = 0;
      end
      if (out7Valid) begin
         if (q7.size() == 0) begin
            checkOutput("z7 spurious out_valid", int'(out7Valid), 0);
         end else begin
            e = q7.pop_front();
            checkOutput("z7 left_sel", int'(left7), e.left);
            checkOutput("z7 right_sel", int'(right7), e.right);
            checkOutput("z7 merge_sel", int'(merge7), e.merge);
            checkOutput("z7 out_err", int'(out7Err), 0);
            checkOutput("z7 latency", cycleCnt - e.cyc, 2);
         end
      end
      if (in7Valid && in7Ready) begin
         e = selFor(7, int'(shift7), 0);
         e.cyc = cycleCnt;
         q7.push_back(e);
      end
      if (out2Valid) begin
         if (q2.size() == 0) begin
            checkOutput("z2 spurious out_valid", int'(out2Valid), 0);
         end else begin
            e = q2.pop_front();
            checkOutput("z2 left_sel", int'(left2), e.left);
            checkOutput("z2 right_sel", int'(right2), e.right);
            checkOutput("z2 merge_sel", int'(merge2), e.merge);
            checkOutput("z2 out_err", int'(out2Err), 0);
            checkOutput("z2 latency", cycleCnt - e.cyc, 2);
         end
      end
      if (in2Valid && in2Ready) begin
         e = selFor(2, int'(shift2), 0);
         e.cyc = cycleCnt;
         q2.push_back(e);
      end
      @(posedge clk);
      #1;
      cycleCnt++;
   endtask

   task automatic applyStimulus(vecT v);
      int tries;
      inValid   = 1'b1;
      shiftIn   = 3'(v.shift);
      deltaMode = v.delta;
      colAddr   = 2'(v.col);
      histClr   = v.clr;
      useTable  = 1'b1;
      tableExp  = '{left: v.left, right: v.right, merge: v.merge, err: v.err, cyc: 0};
      tries     = 0;
      do begin
         cycleStep();
         tries++;
      end while (!lastAccept && tries < 10);
      if (!lastAccept) boundFail("table accept");
      histClr  = 1'b0;
      useTable = 1'b0;
   endtask

   task automatic drain(string name);
      int tries;
      inValid  = 1'b0;
      in7Valid = 1'b0;
      in2Valid = 1'b0;
      outReady = 1'b1;
      tries    = 0;
      while ((q5.size() != 0 || q7.size() != 0 || q2.size() != 0) && tries < 20) begin
         cycleStep();
         tries++;
      end
      if (q5.size() != 0 || q7.size() != 0 || q2.size() != 0) boundFail(name);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, want $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      inValid = 1'b0; shiftIn = '0; colAddr = '0; deltaMode = 1'b0; histClr = 1'b0;
      outReady = 1'b1;
      in7Valid = 1'b0; shift7 = '0; in2Valid = 1'b0; shift2 = '0;
      for (int i = 0; i < 4; i++) modelHist[i] = 0;

      vecs = '{
         '{0, 0, 0, 0, 0, 0,  0, 0}, '{1, 0, 0, 0, 1, 4, 15, 0}, '{2, 0, 0, 0, 2, 3,  7, 0},
         '{3, 0, 0, 0, 3, 2,  3, 0}, '{4, 0, 0, 0, 4, 1,  1, 0}, '{3, 1, 2, 0, 3, 2,  3, 0},
         '{1, 1, 2, 0, 3, 2,  3, 0}, '{1, 1, 2, 0, 0, 0,  0, 0}, '{6, 1, 1, 0, 0, 0,  0, 1},
         '{2, 1, 1, 0, 2, 3,  7, 0}, '{2, 1, 0, 0, 2, 3,  7, 0}, '{3, 1, 3, 0, 3, 2,  3, 0},
         '{4, 1, 0, 1, 4, 1,  1, 0}, '{4, 1, 0, 0, 0, 0,  0, 0}, '{1, 1, 3, 0, 1, 4, 15, 0},
         '{2, 1, 1, 0, 2, 3,  7, 0}, '{0, 1, 2, 0, 0, 0,  0, 0}, '{3, 0, 0, 0, 3, 2,  3, 0},
         '{4, 1, 0, 0, 0, 0,  0, 0}, '{7, 0, 0, 0, 0, 0,  0, 1}, '{5, 1, 2, 0, 0, 0,  0, 1}
      };

      #12;
      checkOutput("reset out_valid", int'(outValid), 0);
      checkOutput("reset left_sel", int'(leftSel), 0);
      checkOutput("reset right_sel", int'(rightSel), 0);
      checkOutput("reset merge_sel", int'(mergeSel), 0);
      checkOutput("reset out_err", int'(outErr), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("in_ready after reset", int'(inReady), 1);

      // Directed vectors: absolute sweep, delta chains, out-of-range and clear-with-accept.
      foreach (vecs[i]) applyStimulus(vecs[i]);
      drain("table drain");

      // Backpressure: two accepts fill the pipe, the third input must wait.
      outReady = 1'b0; inValid = 1'b1; deltaMode = 1'b0; colAddr = '0;
      shiftIn = 3'd1; cycleStep();
      checkOutput("bp accept 1", int'(lastAccept), 1);
      shiftIn = 3'd2; cycleStep();
      checkOutput("bp accept 2", int'(lastAccept), 1);
      shiftIn = 3'd3;
      checkOutput("in_ready stalled", int'(inReady), 0);
      cycleStep();
      checkOutput("bp no accept", int'(lastAccept), 0);
      outReady = 1'b1;
      begin
         int tries = 0;
         do begin cycleStep(); tries++; end while (!lastAccept && tries < 10);
         if (!lastAccept) boundFail("bp accept 3");
      end
      shiftIn = 3'd4; cycleStep();
      checkOutput("bp accept 4", int'(lastAccept), 1);
      drain("bp drain");

      // Repeat the absolute sweep on Z=7 and Z=2 with fixed two-cycle latency.
      for (int i = 0; i < 7; i++) begin
         in7Valid = 1'b1;
         shift7   = 3'(i);
         in2Valid = (i < 2);
         shift2   = 1'(i);
         cycleStep();
      end
      drain("z7/z2 drain");

      // Reset with two delta transactions in flight.
      deltaMode = 1'b1; colAddr = 2'd2; inValid = 1'b1;
      shiftIn = 3'd2; cycleStep();
      shiftIn = 3'd3; cycleStep();
      inValid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async reset out_valid", int'(outValid), 0);
      checkOutput("async reset left_sel", int'(leftSel), 0);
      checkOutput("async reset right_sel", int'(rightSel), 0);
      checkOutput("async reset merge_sel", int'(mergeSel), 0);
      checkOutput("async reset out_err", int'(outErr), 0);
      q5.delete(); q7.delete(); q2.delete();
      for (int i = 0; i < 4; i++) modelHist[i] = 0;
      stallPrev = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus('{1, 1, 2, 0, 1, 4, 15, 0});
      drain("post reset drain");

      // Random traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         inValid   = ($urandom_range(0, 3) != 0);
         outReady  = ($urandom_range(0, 3) != 0);
         shiftIn   = 3'($urandom_range(0, 7));
         deltaMode = 1'($urandom_range(0, 1));
         colAddr   = 2'($urandom_range(0, 3));
         histClr   = ($urandom_range(0, 15) == 0);
         cycleStep();
      end
      histClr = 1'b0;
      drain("random drain");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
